fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory read at a
// time, buffers returned words with their addresses in a small FIFO, and
// steers the external PC (increment after each fetch, load on redirect).
module fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic [15:0] pc_bra_add,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    input  logic        br_valid,
    input  logic [15:0] br_target,
    output logic        ins_valid,
    output logic [15:0] ins_data,
    output logic [15:0] ins_pc,
    input  logic        ins_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_UPD,
        S_DROP,
        S_REDIR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        tgt_q;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [15:0]        pc_mem   [DEPTH];
    logic [15:0]        data_mem [DEPTH];
    logic               push;
    logic               pop;
    logic               fetch_start;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A returning word is kept only if no redirect arrives with it.
    assign push        = (state == S_WAIT) && mem_ack && !br_valid;
    assign pop         = ins_valid && ins_ready;
    assign fetch_start = (state == S_IDLE) && (state_nxt == S_WAIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect during a read waits for that read to finish.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (br_valid) begin
                    state_nxt = S_REDIR;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_nxt = br_valid ? S_REDIR : S_UPD;
                end else if (br_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_UPD:   state_nxt = br_valid ? S_REDIR : S_IDLE;
            S_DROP:  state_nxt = mem_ack ? S_REDIR : S_DROP;
            S_REDIR: state_nxt = br_valid ? S_REDIR : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        mem_req   = 1'b0;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        case (state)
            S_WAIT, S_DROP: mem_req   = 1'b1;
            S_UPD:          pc_inc    = 1'b1;
            S_REDIR:        pc_branch = 1'b1;
            default:        ;
        endcase
    end

    assign pc_bra_add = tgt_q;

    // Redirect target capture; the latest pulse always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q <= '0;
        end else if (br_valid) begin
            tgt_q <= br_target;
        end
    end

    // Read address is latched from the PC when a fetch is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (fetch_start) begin
            mem_addr <= pc_addr;
        end
    end

    // FIFO control; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (rst || br_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage; never written while full, so the head slot is stable.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]   <= mem_addr;
            data_mem[wr_ptr] <= mem_data;
        end
    end

    assign ins_valid = (count != '0);
    assign ins_data  = ins_valid ? data_mem[rd_ptr] : '0;
    assign ins_pc    = ins_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level model (queue of buffered
// words, pending-redirect and abandoned-read flags, external PC register).
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        pc_branch;
    logic [15:0] pc_bra_add;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        br_valid;
    logic [15:0] br_target;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .pc_bra_add (pc_bra_add),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .ins_ready  (ins_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] q_pc[$];
    logic [15:0] q_data[$];
    logic [15:0] pc_tb;
    logic [15:0] last_tgt;
    logic        doomed;
    logic        pending;

    // Observation logs
    int          cyc = 0;
    int          inc_count;
    int          inc_times[$];
    logic [15:0] pops_pc[$];
    logic [15:0] pops_data[$];
    logic [15:0] req_addrs[$];

    // Memory responder controls
    int ack_lat  = 0;
    bit ack_hold = 1'b0;
    bit rand_lat = 1'b0;
    int wait_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] q_at(input logic [15:0] qq[$], input int i);
        return (i < qq.size()) ? qq[i] : 16'hxxxx;
    endfunction

    // Sets mem_ack/mem_data for the next edge from the visible request.
    task automatic drive_mem();
        if (mem_req) begin
            if (wait_cnt == 0 && rand_lat) ack_lat = $urandom_range(0, 3);
            mem_ack = !ack_hold && (wait_cnt >= ack_lat);
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            mem_ack  = 1'b0;
        end
        mem_data = 16'hA000 + mem_addr;
    endtask

    // One clock: advance model with the inputs applied at this edge, then compare.
    task automatic step();
        logic        p_req, p_inc, p_branch;
        logic [15:0] p_pc, p_data, p_bra;
        logic        push_e, exp_branch;
        p_req    = mem_req;
        p_inc    = pc_inc;
        p_branch = pc_branch;
        p_pc     = ins_pc;
        p_data   = ins_data;
        p_bra    = pc_bra_add;
        push_e   = 1'b0;
        @(posedge clk);
        #1;
        cyc++;

        if (rst) begin
            q_pc.delete();
            q_data.delete();
            doomed   = 1'b0;
            pending  = 1'b0;
            last_tgt = 16'h0;
            check("rst_mem_req",   32'(mem_req),    32'(0));
            check("rst_pc_inc",    32'(pc_inc),     32'(0));
            check("rst_pc_branch", 32'(pc_branch),  32'(0));
            check("rst_ins_valid", 32'(ins_valid),  32'(0));
            check("rst_bra_add",   32'(pc_bra_add), 32'(0));
            check("rst_ins_data",  32'(ins_data),   32'(0));
            check("rst_ins_pc",    32'(ins_pc),     32'(0));
        end else begin
            push_e = p_req && mem_ack && !br_valid && !doomed;
            if (br_valid) begin
                q_pc.delete();
                q_data.delete();
                last_tgt = br_target;
            end else begin
                if (q_pc.size() != 0 && ins_ready) begin
                    pops_pc.push_back(p_pc);
                    pops_data.push_back(p_data);
                    void'(q_pc.pop_front());
                    void'(q_data.pop_front());
                end
                if (push_e) begin
                    q_pc.push_back(pc_tb);
                    q_data.push_back(mem_data);
                end
            end
            doomed  = p_req && !mem_ack && (doomed || br_valid);
            pending = br_valid ? 1'b1 : (p_branch ? 1'b0 : pending);
            if (p_branch)   pc_tb = p_bra;
            else if (p_inc) pc_tb = pc_tb + 16'd1;
            exp_branch = pending && !doomed;

            check("pc_inc",    32'(pc_inc),    32'(push_e));
            check("pc_branch", 32'(pc_branch), 32'(exp_branch));
            if (exp_branch) check("pc_bra_add", 32'(pc_bra_add), 32'(last_tgt));
            check("ins_valid", 32'(ins_valid), 32'(q_pc.size() != 0));
            if (q_pc.size() != 0) begin
                check("ins_pc",   32'(ins_pc),   32'(q_pc[0]));
                check("ins_data", 32'(ins_data), 32'(q_data[0]));
            end
            if (p_req && !mem_ack) check("req_held", 32'(mem_req), 32'(1));
            if (mem_req) check("mem_addr", 32'(mem_addr), 32'(pc_tb));
            if (q_pc.size() == DEPTH) check("req_full", 32'(mem_req), 32'(0));
        end
        pc_addr = pc_tb;

        if (pc_inc) begin
            inc_count++;
            inc_times.push_back(cyc);
        end
        if (mem_req && !p_req) req_addrs.push_back(mem_addr);

        br_valid = 1'b0;
        drive_mem();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        inc_count = 0;
        inc_times.delete();
        pops_pc.delete();
        pops_data.delete();
        req_addrs.delete();
    endtask

    task automatic do_reset(input logic [15:0] pc0);
        rst      = 1'b1;
        br_valid = 1'b0;
        pc_tb    = pc0;
        pc_addr  = pc0;
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pc_before;
        rst = 1'b1; br_valid = 1'b0; br_target = '0;
        mem_ack = 1'b0; mem_data = '0; ins_ready = 1'b0;
        pc_tb = '0; pc_addr = '0; last_tgt = '0; doomed = 1'b0; pending = 1'b0;
        clear_logs();

        // S1: zero-wait streaming, consumer always ready
        ins_ready = 1'b1; ack_hold = 1'b0; ack_lat = 0;
        do_reset(16'h0000);
        run(16);
        for (int i = 0; i < 4; i++) begin
            check("s1_pc",   32'(q_at(pops_pc, i)),   32'(i));
            check("s1_data", 32'(q_at(pops_data, i)), 32'(16'hA000 + 16'(i)));
        end
        check("s1_ninc", 32'(inc_times.size() >= 4), 32'(1));
        if (inc_times.size() >= 4)
            for (int i = 0; i < 3; i++)
                check("s1_spacing", 32'(inc_times[i+1] - inc_times[i]), 32'(3));

        // S2: consumer stalled, buffer fills, then drains and fetch resumes
        ins_ready = 1'b0;
        do_reset(16'h0000);
        run(12);
        check("s2_inc_count", 32'(inc_count), 32'(2));
        check("s2_pc_addr",   32'(pc_addr),   32'(2));
        check("s2_mem_req",   32'(mem_req),   32'(0));
        req_addrs.delete();
        ins_ready = 1'b1;
        run(5);
        check("s2_pop0",   32'(q_at(pops_pc, 0)),   32'(0));
        check("s2_resume", 32'(q_at(req_addrs, 0)), 32'(2));

        // S3: redirect during a read whose ack arrives 3 cycles later
        ack_hold = 1'b1; ins_ready = 1'b1;
        do_reset(16'h0000);
        step();
        br_valid = 1'b1; br_target = 16'h0040;
        step();
        run(2);
        check("s3_req_held", 32'(mem_req), 32'(1));
        mem_ack = 1'b1;
        step();
        check("s3_branch", 32'(pc_branch),  32'(1));
        check("s3_target", 32'(pc_bra_add), 32'(16'h0040));
        ack_hold = 1'b0;
        run(8);
        check("s3_first_pc", 32'(q_at(pops_pc, 0)), 32'(16'h0040));

        // S4: redirect and ack in the same cycle
        ack_hold = 1'b1;
        do_reset(16'h0000);
        step();
        br_valid = 1'b1; br_target = 16'h0100; mem_ack = 1'b1;
        step();
        check("s4_valid",  32'(ins_valid),  32'(0));
        check("s4_inc",    32'(pc_inc),     32'(0));
        check("s4_branch", 32'(pc_branch),  32'(1));
        check("s4_target", 32'(pc_bra_add), 32'(16'h0100));
        ack_hold = 1'b0;
        run(8);
        check("s4_first_pc", 32'(q_at(pops_pc, 0)), 32'(16'h0100));

        // S5: second redirect while already redirecting
        ack_hold = 1'b1;
        do_reset(16'h0000);
        br_valid = 1'b1; br_target = 16'h0010;
        step();
        check("s5_target1", 32'(pc_bra_add), 32'(16'h0010));
        br_valid = 1'b1; br_target = 16'h0020;
        step();
        check("s5_target2", 32'(pc_bra_add), 32'(16'h0020));
        ack_hold = 1'b0;
        run(8);
        check("s5_first_req", 32'(q_at(req_addrs, 0)), 32'(16'h0020));
        check("s5_first_pc",  32'(q_at(pops_pc, 0)),   32'(16'h0020));

        // S6: reset in the middle of a read with one word buffered
        ins_ready = 1'b0; ack_hold = 1'b0; ack_lat = 0;
        do_reset(16'h0000);
        step();
        ack_hold = 1'b1;
        run(3);
        check("s6_pre_valid", 32'(ins_valid), 32'(1));
        check("s6_pre_req",   32'(mem_req),   32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_req",   32'(mem_req),   32'(0));
        check("s6_valid", 32'(ins_valid), 32'(0));
        pc_before = pc_addr;
        req_addrs.delete();
        mem_ack = 1'b1;
        step();
        check("s6_late_ack", 32'(ins_valid), 32'(0));
        ack_hold = 1'b0;
        run(6);
        check("s6_restart", 32'(q_at(req_addrs, 0)), 32'(pc_before));

        // Randomized run: random latency, stalls, redirects and resets
        rand_lat = 1'b1; ack_hold = 1'b0;
        do_reset(16'($urandom));
        for (int i = 0; i < 3000; i++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                br_valid  = 1'b1;
                br_target = 16'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
